// File: rtl/ysyx_23060203_pkg.sv
// rtl/ysyx_23060203_pkg.sv - shared types and load helpers for the writeback stage
//
// Contents:
//   LB/LH/LW/LBU/LHU  load funct3 encodings
//   wb_pkt_t          one retiring instruction as handed over by the LSU
//   load_misaligned() access-size alignment check for a load
package ysyx_23060203_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        ebreak;
    } wb_pkt_t;

    // Byte loads never fault; halfword loads need an even address; every
    // other encoding (LW and the unused ones) behaves as a word access.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        case (funct3)
            LB, LBU: return 1'b0;
            LH, LHU: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060203_wbu_if.sv
// rtl/ysyx_23060203_wbu_if.sv - handshake and bus bundle around the writeback stage
//
// Groups:
//   in_*      LSU -> WBU retiring packet (valid/ready)
//   gpr_*     WBU -> register file write port
//   commit_*  WBU -> IFU/difftest retirement (valid/ready)
//   sb_*      IDU <-> scoreboard set/query
//   retire_cnt retired-instruction count
// Modports: slave = the WBU itself, master = its surroundings.
interface ysyx_23060203_wbu_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_dnpc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu;
    logic [31:0] in_rdata;
    logic        in_ebreak;

    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic [31:0] commit_dnpc;
    logic        commit_ebreak;
    logic        commit_err;

    logic        sb_set;
    logic [4:0]  sb_rd;
    logic [4:0]  sb_rs1;
    logic [4:0]  sb_rs2;
    logic        sb_busy1;
    logic        sb_busy2;
    logic        sb_full;

    logic [31:0] retire_cnt;

    modport slave (
        input  in_valid, in_pc, in_dnpc, in_rd, in_rd_wen, in_is_load,
               in_funct3, in_addr_lo, in_alu, in_rdata, in_ebreak,
        output in_ready,
        output gpr_wen, gpr_waddr, gpr_wdata,
        output commit_valid, commit_pc, commit_dnpc, commit_ebreak, commit_err,
        input  commit_ready,
        input  sb_set, sb_rd, sb_rs1, sb_rs2,
        output sb_busy1, sb_busy2, sb_full,
        output retire_cnt
    );

    modport master (
        output in_valid, in_pc, in_dnpc, in_rd, in_rd_wen, in_is_load,
               in_funct3, in_addr_lo, in_alu, in_rdata, in_ebreak,
        input  in_ready,
        input  gpr_wen, gpr_waddr, gpr_wdata,
        input  commit_valid, commit_pc, commit_dnpc, commit_ebreak, commit_err,
        output commit_ready,
        output sb_set, sb_rd, sb_rs1, sb_rs2,
        input  sb_busy1, sb_busy2, sb_full,
        input  retire_cnt
    );

endinterface

// File: rtl/ysyx_23060203_scoreboard.sv
// rtl/ysyx_23060203_scoreboard.sv - per-register in-flight write counters for RAW hazard detection
//
// Ports:
//   clock, reset        clock, asynchronous active-high reset
//   set, set_rd         IDU issued an instruction that will write set_rd
//   clr, clr_rd         an instruction writing clr_rd retired
//   rs1, rs2            source registers being queried
//   busy1, busy2        source has at least one write in flight
//   full                set_rd counter is saturated; the set is dropped
module ysyx_23060203_scoreboard #(
    parameter int NR_REG = 16,
    parameter int CNT_W  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set,
    input  logic [4:0] set_rd,
    input  logic       clr,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       busy1,
    output logic       busy2,
    output logic       full
);

    localparam int IDX_W = (NR_REG > 1) ? $clog2(NR_REG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NR_REG];

    // x0 and indices beyond the implemented register file are never tracked.
    function automatic logic tracked(input logic [4:0] r);
        return (r != 5'd0) && (int'(r) < NR_REG);
    endfunction

    logic [IDX_W-1:0] set_idx, clr_idx, rs1_idx, rs2_idx;
    logic             set_hit, set_en, clr_en;
    logic [NR_REG-1:0] inc_vec, dec_vec;

    assign set_idx = set_rd[IDX_W-1:0];
    assign clr_idx = clr_rd[IDX_W-1:0];
    assign rs1_idx = rs1[IDX_W-1:0];
    assign rs2_idx = rs2[IDX_W-1:0];

    assign set_hit = set && tracked(set_rd);
    assign full    = set_hit && (cnt[set_idx] == CNT_MAX);
    assign set_en  = set_hit && (cnt[set_idx] != CNT_MAX);
    // A retirement against an idle counter would underflow; drop it.
    assign clr_en  = clr && tracked(clr_rd) && (cnt[clr_idx] != '0);

    // Queries see the current counts only; a retirement in this very cycle
    // still reports busy, which merely costs the IDU one extra stall cycle.
    assign busy1 = tracked(rs1) && (cnt[rs1_idx] != '0);
    assign busy2 = tracked(rs2) && (cnt[rs2_idx] != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (set_en) inc_vec[set_idx] = 1'b1;
        if (clr_en) dec_vec[clr_idx] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NR_REG; i++) begin
                // Set and clear of one register in the same cycle cancel out.
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
                    2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// rtl/ysyx_23060203_wbu.sv - RV32E writeback stage: holds one retiring instruction, writes the GPR, retires
//
// Ports:
//   clock  clock
//   reset  asynchronous active-high reset; a held instruction is dropped
//   wb     slave side of ysyx_23060203_wbu_if:
//          in_*      packet from the LSU (accepted when in_valid & in_ready)
//          gpr_*     register-file write, asserted only in the retire cycle
//          commit_*  retirement handshake towards IFU/difftest
//          sb_*      scoreboard set and RAW queries from the IDU
//          retire_cnt number of retired instructions, wraps at 2^32
module ysyx_23060203_wbu
    import ysyx_23060203_pkg::*;
#(
    parameter int NR_REG = 16,
    parameter int CNT_W  = 2
) (
    input  logic               clock,
    input  logic               reset,
    ysyx_23060203_wbu_if.slave wb
);

    wb_pkt_t     in_pkt;
    wb_pkt_t     pkt_q;
    logic        valid_q;
    logic [31:0] retire_q;
    logic        commit_fire;
    logic        accept;
    logic        err;

    // Shift the addressed byte/halfword down to bit 0, then extend by type.
    function automatic logic [31:0] load_align(input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {addr_lo, 3'b000};
        case (funct3)
            LB:      return {{24{sh[7]}}, sh[7:0]};
            LH:      return {{16{sh[15]}}, sh[15:0]};
            LBU:     return {24'h0, sh[7:0]};
            LHU:     return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        in_pkt         = '0;
        in_pkt.pc      = wb.in_pc;
        in_pkt.dnpc    = wb.in_dnpc;
        in_pkt.rd      = wb.in_rd;
        in_pkt.rd_wen  = wb.in_rd_wen;
        in_pkt.is_load = wb.in_is_load;
        in_pkt.funct3  = wb.in_funct3;
        in_pkt.addr_lo = wb.in_addr_lo;
        in_pkt.alu     = wb.in_alu;
        in_pkt.rdata   = wb.in_rdata;
        in_pkt.ebreak  = wb.in_ebreak;
    end

    assign commit_fire = valid_q && wb.commit_ready;
    // Retiring frees the slot in the same cycle, so a new packet can follow
    // back to back while commit_ready stays high.
    assign wb.in_ready = !valid_q || commit_fire;
    assign accept      = wb.in_valid && wb.in_ready;

    assign err = valid_q && pkt_q.is_load && load_misaligned(pkt_q.funct3, pkt_q.addr_lo);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pkt_q    <= '0;
            retire_q <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                pkt_q   <= in_pkt;
            end else if (commit_fire) begin
                valid_q <= 1'b0;
            end
            if (commit_fire) retire_q <= retire_q + 32'd1;
        end
    end

    assign wb.commit_valid  = valid_q;
    assign wb.commit_pc     = pkt_q.pc;
    assign wb.commit_dnpc   = pkt_q.dnpc;
    assign wb.commit_ebreak = pkt_q.ebreak;
    assign wb.commit_err    = err;
    assign wb.retire_cnt    = retire_q;

    // A misaligned load still retires, but must not corrupt the register.
    assign wb.gpr_wen   = commit_fire && pkt_q.rd_wen && (pkt_q.rd != 5'd0) && !err;
    assign wb.gpr_waddr = pkt_q.rd;
    assign wb.gpr_wdata = pkt_q.is_load ? load_align(pkt_q.funct3, pkt_q.addr_lo, pkt_q.rdata)
                                        : pkt_q.alu;

    // The scoreboard is released on every retirement that was going to write
    // rd, including a faulting load, because the IDU counted it at issue.
    ysyx_23060203_scoreboard #(
        .NR_REG (NR_REG),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clock  (clock),
        .reset  (reset),
        .set    (wb.sb_set),
        .set_rd (wb.sb_rd),
        .clr    (commit_fire && pkt_q.rd_wen),
        .clr_rd (pkt_q.rd),
        .rs1    (wb.sb_rs1),
        .rs2    (wb.sb_rs2),
        .busy1  (wb.sb_busy1),
        .busy2  (wb.sb_busy2),
        .full   (wb.sb_full)
    );

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// tb/tb_ysyx_23060203_wbu.sv - self-checking bench for ysyx_23060203_wbu
module tb_ysyx_23060203_wbu;
    import ysyx_23060203_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_23060203_wbu_if bus();

    ysyx_23060203_wbu dut (
        .clock (clock),
        .reset (reset),
        .wb    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        if (f3 == LB || f3 == LBU) return 1;
        if (f3 == LH || f3 == LHU) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input wb_pkt_t p);
        return p.is_load && ((int'(p.addr_lo) % access_size(p.funct3)) != 0);
    endfunction

    function automatic logic [31:0] model_data(input wb_pkt_t p);
        longint v, span;
        if (!p.is_load) return p.alu;
        v    = longint'(p.rdata) / (longint'(1) << (8 * int'(p.addr_lo)));
        span = longint'(1) << (8 * access_size(p.funct3));
        v    = v % span;
        if ((p.funct3 == LB || p.funct3 == LH) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    logic        m_valid;
    wb_pkt_t     m_pkt;
    logic [31:0] m_retire;
    int          m_cnt [16];
    wb_pkt_t     drv_pkt;

    function automatic logic in_rng(input logic [4:0] r);
        return r != 5'd0 && int'(r) < 16;
    endfunction

    function automatic int cnt_of(input logic [4:0] r);
        if (!in_rng(r)) return 0;
        return m_cnt[int'(r)];
    endfunction

    logic m_fire, m_accept, c_err, c_wen;
    assign m_fire   = m_valid && bus.commit_ready;
    assign m_accept = bus.in_valid && (!m_valid || m_fire);
    assign c_err    = m_valid && model_err(m_pkt);
    assign c_wen    = m_fire && m_pkt.rd_wen && (m_pkt.rd != 5'd0) && !c_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_pkt    <= '0;
            m_retire <= '0;
            for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
        end else begin
            if (m_accept) begin
                m_valid <= 1'b1;
                m_pkt   <= drv_pkt;
            end else if (m_fire) begin
                m_valid <= 1'b0;
            end
            if (m_fire) m_retire <= m_retire + 32'd1;
            for (int i = 1; i < 16; i++)
                m_cnt[i] <= m_cnt[i]
                    + ((bus.sb_set && int'(bus.sb_rd) == i && m_cnt[i] < 3) ? 1 : 0)
                    - ((m_fire && m_pkt.rd_wen && int'(m_pkt.rd) == i && m_cnt[i] > 0) ? 1 : 0);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check_b("in_ready", bus.in_ready, !m_valid || m_fire);
            check_b("commit_valid", bus.commit_valid, m_valid);
            check_b("commit_err", bus.commit_err, c_err);
            check_b("gpr_wen", bus.gpr_wen, c_wen);
            check("retire_cnt", bus.retire_cnt, m_retire);
            check_b("sb_busy1", bus.sb_busy1, cnt_of(bus.sb_rs1) != 0);
            check_b("sb_busy2", bus.sb_busy2, cnt_of(bus.sb_rs2) != 0);
            check_b("sb_full", bus.sb_full, bus.sb_set && cnt_of(bus.sb_rd) == 3);
            if (m_valid) begin
                check("commit_pc", bus.commit_pc, m_pkt.pc);
                check("commit_dnpc", bus.commit_dnpc, m_pkt.dnpc);
                check_b("commit_ebreak", bus.commit_ebreak, m_pkt.ebreak);
            end
            if (c_wen) begin
                check("gpr_waddr", {27'b0, bus.gpr_waddr}, {27'b0, m_pkt.rd});
                check("gpr_wdata", bus.gpr_wdata, model_data(m_pkt));
            end
            if (m_fire && m_pkt.rd_wen && in_rng(m_pkt.rd))
                check_b("sb_clear_nonzero", cnt_of(m_pkt.rd) != 0, 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pc_ctr = 32'h8000_0000;

    function automatic wb_pkt_t mk(input logic [4:0] rd, input logic wen, input logic ld,
                                   input logic [2:0] f3, input logic [1:0] a,
                                   input logic [31:0] alu, input logic [31:0] rdata,
                                   input logic eb);
        wb_pkt_t p;
        p         = '0;
        p.pc      = pc_ctr;
        p.dnpc    = pc_ctr + 32'd4;
        pc_ctr    = pc_ctr + 32'd4;
        p.rd      = rd;
        p.rd_wen  = wen;
        p.is_load = ld;
        p.funct3  = f3;
        p.addr_lo = a;
        p.alu     = alu;
        p.rdata   = rdata;
        p.ebreak  = eb;
        return p;
    endfunction

    task automatic drive(input wb_pkt_t p, input logic v, input logic s);
        drv_pkt        = p;
        bus.in_valid   = v;
        bus.in_pc      = p.pc;
        bus.in_dnpc    = p.dnpc;
        bus.in_rd      = p.rd;
        bus.in_rd_wen  = p.rd_wen;
        bus.in_is_load = p.is_load;
        bus.in_funct3  = p.funct3;
        bus.in_addr_lo = p.addr_lo;
        bus.in_alu     = p.alu;
        bus.in_rdata   = p.rdata;
        bus.in_ebreak  = p.ebreak;
        bus.sb_set     = s;
        bus.sb_rd      = p.rd;
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Presents a packet for one cycle; returns in the cycle it is held.
    task automatic send(input wb_pkt_t p, input logic s);
        cyc();
        drive(p, 1'b1, s);
        cyc();
        bus.in_valid = 1'b0;
        bus.sb_set   = 1'b0;
    endtask

    wb_pkt_t p;
    logic [2:0]  ld_f3  [4] = '{LB, LBU, LH, LW};
    logic [1:0]  ld_a   [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] ld_exp [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h80FF_7F01};
    logic [31:0] n_ret;

    initial begin
        reset = 1'b1;
        drive('0, 1'b0, 1'b0);
        bus.commit_ready = 1'b1;
        bus.sb_rs1 = 5'd0;
        bus.sb_rs2 = 5'd0;
        repeat (2) @(posedge clock);
        #2;
        check_b("rst commit_valid", bus.commit_valid, 1'b0);
        check_b("rst gpr_wen", bus.gpr_wen, 1'b0);
        check_b("rst commit_err", bus.commit_err, 1'b0);
        check("rst commit_pc", bus.commit_pc, 32'h0);
        check("rst retire_cnt", bus.retire_cnt, 32'h0);
        check_b("rst in_ready", bus.in_ready, 1'b1);
        reset = 1'b0;

        // ALU write
        send(mk(5'd5, 1'b1, 1'b0, LW, 2'd0, 32'h1234, 32'h0, 1'b0), 1'b1);
        @(negedge clock);
        check_b("alu wen", bus.gpr_wen, 1'b1);
        check("alu waddr", {27'b0, bus.gpr_waddr}, 32'd5);
        check("alu wdata", bus.gpr_wdata, 32'h1234);
        cyc();
        check("alu retire", bus.retire_cnt, 32'd1);

        // loads of 0x80FF7F01
        for (int k = 0; k < 4; k++) begin
            p = mk(5'(6 + k), 1'b1, 1'b1, ld_f3[k], ld_a[k], 32'h0, 32'h80FF_7F01, 1'b0);
            check("model load", model_data(p), ld_exp[k]);
            send(p, 1'b1);
            @(negedge clock);
            check_b("load wen", bus.gpr_wen, 1'b1);
            check("load wdata", bus.gpr_wdata, ld_exp[k]);
        end

        // back-pressure
        cyc();
        bus.commit_ready = 1'b0;
        p = mk(5'd10, 1'b1, 1'b0, LW, 2'd0, 32'hAAAA, 32'h0, 1'b0);
        drive(p, 1'b1, 1'b1);
        cyc();
        drive(mk(5'd11, 1'b1, 1'b0, LW, 2'd0, 32'hBBBB, 32'h0, 1'b0), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_b("bp in_ready", bus.in_ready, 1'b0);
            check_b("bp wen", bus.gpr_wen, 1'b0);
            check("bp held pc", bus.commit_pc, p.pc);
            cyc();
            bus.sb_set = 1'b0;
        end
        bus.commit_ready = 1'b1;
        @(negedge clock);
        check_b("bp release wen", bus.gpr_wen, 1'b1);
        check("bp release waddr", {27'b0, bus.gpr_waddr}, 32'd10);
        check_b("bp release in_ready", bus.in_ready, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("bp next waddr", {27'b0, bus.gpr_waddr}, 32'd11);
        check("bp next wdata", bus.gpr_wdata, 32'hBBBB);

        // scoreboard: two sets, two clears
        cyc();
        bus.sb_set = 1'b1; bus.sb_rd = 5'd3;
        cyc();
        cyc();
        bus.sb_set = 1'b0; bus.sb_rs1 = 5'd3;
        @(negedge clock);
        check_b("sb busy after 2 sets", bus.sb_busy1, 1'b1);
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h33, 32'h0, 1'b0), 1'b0);
        cyc();
        check_b("sb busy after 1 clear", bus.sb_busy1, 1'b1);
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h34, 32'h0, 1'b0), 1'b0);
        cyc();
        check_b("sb idle after 2 clears", bus.sb_busy1, 1'b0);
        // saturate then probe full
        bus.sb_set = 1'b1; bus.sb_rd = 5'd3;
        repeat (3) cyc();
        @(negedge clock);
        check_b("sb full", bus.sb_full, 1'b1);
        cyc();
        bus.sb_set = 1'b0;
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h35, 32'h0, 1'b0), 1'b0);
        // count now 2; clear and set together must keep it at 2
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h36, 32'h0, 1'b0), 1'b0);
        bus.sb_set = 1'b1; bus.sb_rd = 5'd3;
        @(negedge clock);
        check_b("sb not full at 2", bus.sb_full, 1'b0);
        cyc();
        bus.sb_set = 1'b0;
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h37, 32'h0, 1'b0), 1'b0);
        cyc();
        check_b("sb set+clr kept count", bus.sb_busy1, 1'b1);
        send(mk(5'd3, 1'b1, 1'b0, LW, 2'd0, 32'h38, 32'h0, 1'b0), 1'b0);
        cyc();
        check_b("sb drained", bus.sb_busy1, 1'b0);

        // x0 destination, ebreak
        send(mk(5'd0, 1'b1, 1'b0, LW, 2'd0, 32'hDEAD, 32'h0, 1'b1), 1'b1);
        bus.sb_rs1 = 5'd0;
        @(negedge clock);
        check_b("x0 wen", bus.gpr_wen, 1'b0);
        check_b("x0 ebreak", bus.commit_ebreak, 1'b1);
        check_b("x0 busy", bus.sb_busy1, 1'b0);

        // out-of-range indices
        cyc();
        bus.sb_set = 1'b1; bus.sb_rd = 5'd20; bus.sb_rs1 = 5'd20; bus.sb_rs2 = 5'd20;
        @(negedge clock);
        check_b("oor full", bus.sb_full, 1'b0);
        cyc();
        bus.sb_set = 1'b0;
        @(negedge clock);
        check_b("oor busy", bus.sb_busy1, 1'b0);

        // misaligned LW
        n_ret = bus.retire_cnt;
        bus.sb_rs2 = 5'd12;
        send(mk(5'd12, 1'b1, 1'b1, LW, 2'd2, 32'h0, 32'h1234_5678, 1'b0), 1'b1);
        @(negedge clock);
        check_b("mis err", bus.commit_err, 1'b1);
        check_b("mis wen", bus.gpr_wen, 1'b0);
        cyc();
        check("mis retire", bus.retire_cnt, n_ret + 32'd1);
        check_b("mis sb cleared", bus.sb_busy2, 1'b0);

        // asynchronous reset while holding
        bus.commit_ready = 1'b0;
        bus.sb_rs1 = 5'd4;
        send(mk(5'd4, 1'b1, 1'b0, LW, 2'd0, 32'h44, 32'h0, 1'b0), 1'b1);
        cyc();
        check_b("hold valid", bus.commit_valid, 1'b1);
        check_b("hold busy", bus.sb_busy1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_b("arst commit_valid", bus.commit_valid, 1'b0);
        check("arst retire", bus.retire_cnt, 32'h0);
        check_b("arst busy", bus.sb_busy1, 1'b0);
        check_b("arst wen", bus.gpr_wen, 1'b0);
        check("arst commit_pc", bus.commit_pc, 32'h0);
        bus.commit_ready = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        check("post rst retire", bus.retire_cnt, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
